// File: rtl/pong_match_ctrl_if.sv
// Signal bundle between the pong input/animation logic and the match sequencer.
// The testbench or pong top drives through master; pong_match_ctrl uses slave.
interface pong_match_ctrl_if;
  logic       frame_tick;
  logic       start;
  logic       pause;
  logic       miss_left;
  logic       miss_right;
  logic       ball_enable;
  logic       ball_reset;
  logic       serve_dir;
  logic [3:0] score1;
  logic [3:0] score2;
  logic       game_over;
  logic [1:0] winner;
  logic [2:0] state_dbg;

  modport master (
    output frame_tick, start, pause, miss_left, miss_right,
    input  ball_enable, ball_reset, serve_dir, score1, score2,
           game_over, winner, state_dbg
  );

  modport slave (
    input  frame_tick, start, pause, miss_left, miss_right,
    output ball_enable, ball_reset, serve_dir, score1, score2,
           game_over, winner, state_dbg
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve hold, play/pause gating, scoring and winner.
// Define PONG_WIN_BY_TWO_EN to require a two-point lead, with deuce fold.
module pong_match_ctrl #(
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_DELAY = 60
) (
  input logic               clk,
  input logic               reset,
  pong_match_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_PLAY       = 3'd2,
    ST_POINT      = 3'd3,
    ST_GAME_OVER  = 3'd4
  } state_t;

  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam logic [7:0] DELAY_LAST = 8'(SERVE_DELAY - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [3:0] r_score1;
  logic [3:0] r_score2;
  logic       r_serve_dir;
  logic [1:0] r_winner;
  logic       r_ball_enable;
  logic       r_ball_reset;
  logic       r_game_over;

  state_t     w_state_nxt;
  logic [7:0] w_cnt_nxt;
  logic [3:0] w_score1_nxt;
  logic [3:0] w_score2_nxt;
  logic       w_serve_dir_nxt;
  logic [1:0] w_winner_nxt;
  logic       w_win_p1;
  logic       w_win_p2;
  logic       w_deuce;
  logic       w_miss_valid;

  // Extended to 5 bits so score+2 cannot wrap near the top of the 4-bit range.
`ifdef PONG_WIN_BY_TWO_EN
  assign w_win_p1 = (r_score1 >= WIN) && ({1'b0, r_score1} >= {1'b0, r_score2} + 5'd2);
  assign w_win_p2 = (r_score2 >= WIN) && ({1'b0, r_score2} >= {1'b0, r_score1} + 5'd2);
  assign w_deuce  = (r_score1 == WIN) && (r_score2 == WIN);
`else
  assign w_win_p1 = (r_score1 >= WIN);
  assign w_win_p2 = (r_score2 >= WIN);
  assign w_deuce  = 1'b0;
`endif

  assign w_miss_valid = !bus.pause && (bus.miss_left ^ bus.miss_right);

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_score1_nxt    = r_score1;
    w_score2_nxt    = r_score2;
    w_serve_dir_nxt = r_serve_dir;
    w_winner_nxt    = r_winner;
    unique case (r_state)
      ST_IDLE: begin
        w_score1_nxt = 4'd0;
        w_score2_nxt = 4'd0;
        if (bus.start) begin
          w_state_nxt     = ST_SERVE_WAIT;
          w_cnt_nxt       = 8'd0;
          w_serve_dir_nxt = 1'b0;
        end
      end
      ST_SERVE_WAIT: begin
        if (bus.frame_tick) begin
          w_cnt_nxt = r_cnt + 8'd1;
          if (r_cnt == DELAY_LAST) w_state_nxt = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (w_miss_valid) begin
          w_state_nxt = ST_POINT;
          if (bus.miss_left) begin
            w_score2_nxt    = r_score2 + 4'd1;
            w_serve_dir_nxt = 1'b1;
          end else begin
            w_score1_nxt    = r_score1 + 4'd1;
            w_serve_dir_nxt = 1'b0;
          end
        end
      end
      ST_POINT: begin
        if (w_win_p1 || w_win_p2) begin
          w_state_nxt  = ST_GAME_OVER;
          w_winner_nxt = w_win_p1 ? 2'b01 : 2'b10;
        end else begin
          w_state_nxt = ST_SERVE_WAIT;
          w_cnt_nxt   = 8'd0;
          if (w_deuce) begin
            w_score1_nxt = WIN - 4'd1;
            w_score2_nxt = WIN - 4'd1;
          end
        end
      end
      ST_GAME_OVER: begin
        if (bus.start) begin
          w_state_nxt     = ST_SERVE_WAIT;
          w_cnt_nxt       = 8'd0;
          w_score1_nxt    = 4'd0;
          w_score2_nxt    = 4'd0;
          w_winner_nxt    = 2'b00;
          w_serve_dir_nxt = 1'b0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt         <= 8'd0;
      r_score1      <= 4'd0;
      r_score2      <= 4'd0;
      r_serve_dir   <= 1'b0;
      r_winner      <= 2'b00;
      r_ball_enable <= 1'b0;
      r_ball_reset  <= 1'b1;
      r_game_over   <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_score1      <= w_score1_nxt;
      r_score2      <= w_score2_nxt;
      r_serve_dir   <= w_serve_dir_nxt;
      r_winner      <= w_winner_nxt;
      r_ball_enable <= (w_state_nxt == ST_PLAY) && !bus.pause;
      r_ball_reset  <= (w_state_nxt != ST_PLAY);
      r_game_over   <= (w_state_nxt == ST_GAME_OVER);
    end
  end

  assign bus.ball_enable = r_ball_enable;
  assign bus.ball_reset  = r_ball_reset;
  assign bus.serve_dir   = r_serve_dir;
  assign bus.score1      = r_score1;
  assign bus.score2      = r_score2;
  assign bus.game_over   = r_game_over;
  assign bus.winner      = r_winner;
  assign bus.state_dbg   = r_state;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scoreboard bench for pong_match_ctrl: a rule-level match model queues the
// expected outputs per edge; a monitor pops and compares them after each edge.
module tb_pong_match_ctrl;
  localparam int WIN   = 9;
  localparam int DELAY = 60;

  localparam int M_IDLE  = 0;
  localparam int M_SERVE = 1;
  localparam int M_PLAY  = 2;
  localparam int M_POINT = 3;
  localparam int M_OVER  = 4;

  logic clk = 1'b0;
  logic reset;
  pong_match_ctrl_if bus ();

  pong_match_ctrl #(.WIN_SCORE(WIN), .SERVE_DELAY(DELAY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected word: {state[2:0], ball_enable, ball_reset, serve_dir, score1[3:0], score2[3:0], game_over, winner[1:0]}
  logic [16:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  int m_mode = M_IDLE;
  int m_s1 = 0, m_s2 = 0, m_ticks = 0, m_dir = 0, m_win = 0;
  bit m_ben = 1'b0;

  function automatic string fmt(input logic [16:0] v);
    return $sformatf("st=%0d en=%0b rst=%0b dir=%0b s1=%0d s2=%0d go=%0b win=%0d",
                     v[16:14], v[13], v[12], v[11], v[10:7], v[6:3], v[2], v[1:0]);
  endfunction

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp,
                       input bit decode);
    total++;
    if (act !== exp) begin
      bad++;
      if (decode) $display("FAIL %s: got {%s} want {%s}", name, fmt(act), fmt(exp));
      else        $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Match rules: first to WIN, or first to WIN with a two-point lead.
  function automatic int winner_of(input int a, input int b);
`ifdef PONG_WIN_BY_TWO_EN
    if (a >= WIN && a - b >= 2) return 1;
    if (b >= WIN && b - a >= 2) return 2;
`else
    if (a >= WIN) return 1;
    if (b >= WIN) return 2;
`endif
    return 0;
  endfunction

  task automatic model_step(input bit r, input bit st, input bit pa,
                            input bit ml, input bit mr, input bit ft);
    int w;
    if (r) begin
      m_mode = M_IDLE; m_s1 = 0; m_s2 = 0; m_dir = 0; m_win = 0; m_ticks = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (st) begin m_mode = M_SERVE; m_ticks = 0; m_dir = 0; end
        M_SERVE: if (ft) begin
          m_ticks = m_ticks + 1;
          if (m_ticks == DELAY) m_mode = M_PLAY;
        end
        M_PLAY: if (!pa && (ml != mr)) begin
          if (ml) begin m_s2 = m_s2 + 1; m_dir = 1; end
          else    begin m_s1 = m_s1 + 1; m_dir = 0; end
          m_mode = M_POINT;
        end
        M_POINT: begin
          w = winner_of(m_s1, m_s2);
          if (w != 0) begin
            m_win = w; m_mode = M_OVER;
          end else begin
`ifdef PONG_WIN_BY_TWO_EN
            if (m_s1 == WIN && m_s2 == WIN) begin m_s1 = WIN - 1; m_s2 = WIN - 1; end
`endif
            m_mode = M_SERVE; m_ticks = 0;
          end
        end
        M_OVER: if (st) begin
          m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 0; m_mode = M_SERVE; m_ticks = 0;
        end
        default: m_mode = M_IDLE;
      endcase
    end
    m_ben = (m_mode == M_PLAY) && !pa;
    exp_q.push_back({3'(m_mode), m_ben, 1'(m_mode != M_PLAY), 1'(m_dir),
                     4'(m_s1), 4'(m_s2), 1'(m_mode == M_OVER), 2'(m_win)});
  endtask

  task automatic drive(input bit r, input bit st, input bit pa,
                       input bit ml, input bit mr, input bit ft);
    @(negedge clk);
    reset          = r;
    bus.start      = st;
    bus.pause      = pa;
    bus.miss_left  = ml;
    bus.miss_right = mr;
    bus.frame_tick = ft;
    model_step(r, st, pa, ml, mr, ft);
  endtask

  // Start a match if needed, tick through the serve, then let `who` score.
  task automatic point(input int who);
    for (int i = 0; i < 400 && m_mode != M_PLAY; i++)
      drive(1'b0, (m_mode == M_IDLE || m_mode == M_OVER), 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, who == 2, who == 1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reach_play();
    for (int i = 0; i < 400 && m_mode != M_PLAY; i++)
      drive(1'b0, (m_mode == M_IDLE || m_mode == M_OVER), 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin : monitor
    logic [16:0] exp;
    logic [16:0] act;
    int cyc = 0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        act = {bus.state_dbg, bus.ball_enable, bus.ball_reset, bus.serve_dir,
               bus.score1, bus.score2, bus.game_over, bus.winner};
        check($sformatf("outputs cyc %0d", cyc), act, exp, 1'b1);
      end
    end
  end

  initial begin : stimulus
    bit pa = 1'b0;
    reset = 1'b1;
    bus.start = 1'b0; bus.pause = 1'b0; bus.miss_left = 1'b0;
    bus.miss_right = 1'b0; bus.frame_tick = 1'b0;

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // First serve, then a right miss scores for player 1.
    point(1);

    // Simultaneous misses are a no-op; misses under pause are ignored.
    reach_play();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Player 1 runs out the match, then a restart from game over.
    for (int i = 0; i < WIN - 1; i++) point(1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Trade points to 8/8, go 9/8, concede to 9/9, then two more for player 1.
    for (int i = 0; i < WIN - 1; i++) begin point(1); point(2); end
    point(1);
    point(2);
    point(1);
    point(1);

    // Reset in the middle of a rally.
    reach_play();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int c = 0; c < 20000; c++) begin
      if ($urandom_range(15) == 0) pa = ~pa;
      drive($urandom_range(7999) == 0, $urandom_range(31) == 0, pa,
            $urandom_range(9) == 0, $urandom_range(9) == 0, 1'($urandom_range(1)));
    end

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #4;
    check("scoreboard drained", 17'(exp_q.size()), 17'd0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Match sequencer for the two-player pong top level. It sits between the button/tick inputs and the animation datapath. It decides when the ball is held at centre, when it is released and in which direction, and when play is paused. It also owns both 4-bit score counters that feed the seven-segment display controller, and it declares the winner.

## Interface
Parameters:
- WIN_SCORE, 9: points needed to win. Legal range 1..14.
- SERVE_DELAY, 60: number of frame_tick pulses the ball is held at centre before release. Legal range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock; all state is cleared on the clk edge where reset=1
- frame_tick  in  1  one-cycle pulse per video frame
- start  in  1  one-cycle pulse (debounced button): begin match / new match
- pause  in  1  level; freezes ball while in PLAY
- miss_left  in  1  one-cycle pulse: ball passed player-1 (left) paddle
- miss_right  in  1  one-cycle pulse: ball passed player-2 (right) paddle
- ball_enable  out  1  animation may move ball this cycle
- ball_reset  out  1  hold ball at centre
- serve_dir  out  1  0 = serve toward right, 1 = toward left
- score1  out  4  player-1 (left) score
- score2  out  4  player-2 (right) score
- game_over  out  1  match finished
- winner  out  2  00 none, 01 player 1, 10 player 2
- state_dbg  out  3  current state encoding

## Operation
- States, with encoding: IDLE=0, SERVE_WAIT=1, PLAY=2, POINT=3, GAME_OVER=4.
- IDLE:
  - ball_reset=1 and ball_enable=0.
  - Scores are held at 0.
  - start → SERVE_WAIT with serve_dir=0.
- SERVE_WAIT:
  - ball_reset=1 and ball_enable=0.
  - The delay counter clears on entry and increments on each frame_tick.
  - When the count reaches SERVE_DELAY → PLAY, on the same edge that registers the final tick.
- PLAY:
  - ball_reset=0.
  - ball_enable=~pause.
  - miss_left alone → score2+1 and serve_dir=1 (the serve goes toward the player who conceded); → POINT.
  - miss_right alone → score1+1 and serve_dir=0; → POINT.
  - miss_left and miss_right in the same cycle → no score change and stay in PLAY.
  - Misses are ignored while pause=1.
  - Misses are ignored in every state other than PLAY.
- POINT: single cycle, with ball_reset=1.
  - If either score ≥ WIN_SCORE (subject to the win rule under Configuration) → GAME_OVER, and winner is latched.
  - Otherwise → SERVE_WAIT.
- GAME_OVER:
  - ball_reset=1 and game_over=1.
  - Scores and winner are held.
  - start → clear both scores, clear winner, serve_dir=0, → SERVE_WAIT.
- start is ignored in SERVE_WAIT, PLAY and POINT.
- Score arithmetic is 4-bit unsigned. Wrap-around cannot occur given the WIN_SCORE range.

## Timing
- All outputs are registered. Reset value of every output is 0, except ball_reset=1. state_dbg resets to IDLE.
- From a miss pulse in cycle n:
  - the score updates at edge n+1 and the state becomes POINT;
  - at edge n+2 the state becomes SERVE_WAIT or GAME_OVER;
  - game_over and winner are valid from edge n+2.
- ball_enable falls at edge n+1 after a miss. ball_reset rises at the same edge.
- From start in IDLE/GAME_OVER at cycle n: SERVE_WAIT from edge n+1. Scores are already 0 at edge n+1.
- pause affects ball_enable with a 1-cycle registered latency.
- reset asserted mid-match overrides all inputs. The next state is IDLE with scores 0.
- A frame_tick coincident with state entry into SERVE_WAIT is not counted.

## Configuration
- Macro: PONG_WIN_BY_TWO_EN.
- Undefined (default): the match is won when a score reaches WIN_SCORE.
- Defined: win requires score ≥ WIN_SCORE and a lead ≥ 2.
  - When both scores equal WIN_SCORE in POINT, both are set to WIN_SCORE−1 (deuce fold), and the state goes to SERVE_WAIT.
  - The maximum reachable score is WIN_SCORE+1, which stays within 4 bits.

## Test plan
- Reset, then start, then 60 frame_ticks → ball_enable=1 on the cycle after the 60th tick; serve_dir=0; scores 0/0.
- In PLAY, inject miss_right → score1=1 one cycle later; state goes POINT then SERVE_WAIT; serve_dir=0; ball_reset=1 until 60 ticks elapse.
- Bring score1 to 9 with WIN_SCORE=9 → game_over=1, winner=01; then start → scores 0/0, game_over=0, state SERVE_WAIT.
- In PLAY, drive miss_left and miss_right in the same cycle → scores unchanged and state stays PLAY. Hold pause=1 and inject miss_left → no score change, and ball_enable=0 one cycle after pause rises.
- With PONG_WIN_BY_TWO_EN and scores 9/8, miss_left → scores fold to 8/8, no game_over. Then two miss_right pulses → scores 10/8 → winner=01.
- Assert reset during PLAY at score 3/5 → next cycle state IDLE, scores 0/0, ball_reset=1, ball_enable=0.
